// File: rtl/fb_wb_responder_pkg.sv
// fb_wb_responder_pkg: shared widths and FSM encoding for the framebuffer Wishbone responder.
//   WB_DW   Wishbone data width (32)
//   WB_SW   Wishbone byte-select width (4); sel[k] owns dat[8k+7:8k], so sel[3] is dat[31:24]
//   state_t responder FSM states
package fb_wb_responder_pkg;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP, ST_GAP} state_t;
endpackage

// File: rtl/fb_wb_responder_ram.sv
// fb_wb_responder_ram: single-port synchronous RAM, 4 byte enables, registered read.
//   i_clk   clock
//   i_we    write enable; bytes with i_sel[k]=1 are written
//   i_re    read enable; o_dat loads the addressed word and otherwise holds
//   i_sel   byte lanes
//   i_addr  word index
//   i_dat   write data
//   o_dat   registered read data
module fb_wb_responder_ram
    import fb_wb_responder_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [WB_SW-1:0] i_sel,
    input  logic [AW-1:0]    i_addr,
    input  logic [WB_DW-1:0] i_dat,
    output logic [WB_DW-1:0] o_dat
);
    logic [WB_DW-1:0] r_mem [DEPTH];
    logic [WB_DW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < WB_SW; b++)
            if (i_we && i_sel[b]) r_mem[i_addr][8*b +: 8] <= i_dat[8*b +: 8];
        if (i_re) r_q <= r_mem[i_addr];
    end

    assign o_dat = r_q;
endmodule

// File: rtl/fb_wb_responder.sv
// fb_wb_responder: Wishbone responder serving a byte-enabled framebuffer RAM, one ack/err per request.
//   i_wb_clk   clock
//   i_wb_rst   synchronous active-high reset
//   i_wb_addr  byte address, bits [1:0] ignored
//   i_wb_cyc   bus cycle active
//   i_wb_stb   strobe; request = cyc & stb
//   i_wb_we    1 = write, 0 = read
//   i_wb_sel   byte lanes, sel[3] -> dat[31:24]
//   i_wb_dat   write data
//   o_wb_dat   read data, zero unless o_wb_ack
//   o_wb_ack   one-cycle transfer acknowledge
//   o_wb_err   one-cycle error for out-of-range addresses
// MEM_INIT names an initial-contents image for the implementation tool's memory
// initialisation flow; the RAM array carries no reset.
module fb_wb_responder
    import fb_wb_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LATENCY  = 2,
    parameter string       MEM_INIT    = ""
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst,
    input  logic [31:0]      i_wb_addr,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [WB_SW-1:0] i_wb_sel,
    input  logic [WB_DW-1:0] i_wb_dat,
    output logic [WB_DW-1:0] o_wb_dat,
    output logic             o_wb_ack,
    output logic             o_wb_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit unused_mem_init = (MEM_INIT != "");

    state_t           r_state, w_next;
    logic [2:0]       r_cnt, w_cnt_next;
    logic             r_err, w_err_next;
    logic [31:0]      w_off;
    logic             w_req, w_in_range, w_accept, w_ram_we, w_ram_re;
    logic [WB_DW-1:0] w_ram_q, w_rd;
    logic             w_unused;

    assign w_req      = i_wb_cyc & i_wb_stb;
    assign w_off      = i_wb_addr - ADDR_BASE;
    assign w_in_range = (i_wb_addr >= ADDR_BASE) && (w_off[31:2] < 30'(DEPTH_WORDS));
    assign w_accept   = (r_state == ST_IDLE) && w_req && !i_wb_rst;
    // Writes commit on the accepting edge, so the ack that follows reports a completed write.
    assign w_ram_we   = w_accept & i_wb_we & w_in_range;
    assign w_ram_re   = w_accept & ~i_wb_we & w_in_range;
    assign w_unused   = ^w_off[1:0];

    fb_wb_responder_ram #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
        .i_clk  (i_wb_clk),
        .i_we   (w_ram_we),
        .i_re   (w_ram_re),
        .i_sel  (i_wb_sel),
        .i_addr (w_off[AW+1:2]),
        .i_dat  (i_wb_dat),
        .o_dat  (w_ram_q)
    );

    // RAM output holds between reads, so the pipe simply delays it to the ack cycle.
    generate
        if (RD_LATENCY == 1) begin : g_nopipe
            assign w_rd = w_ram_q;
        end else begin : g_pipe
            logic [WB_DW-1:0] r_pipe [RD_LATENCY-1];
            always_ff @(posedge i_wb_clk) begin
                r_pipe[0] <= w_ram_q;
                for (int i = 1; i < RD_LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
            end
            assign w_rd = r_pipe[RD_LATENCY-2];
        end
    endgenerate

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_err_next = r_err;
        case (r_state)
            ST_IDLE: if (w_req) begin
                w_err_next = ~w_in_range;
                w_next     = (w_in_range && !i_wb_we && RD_LATENCY > 1) ? ST_BUSY : ST_RESP;
                w_cnt_next = 3'(RD_LATENCY - 1);
            end
            ST_BUSY: begin
                w_next     = !i_wb_cyc ? ST_IDLE : (r_cnt == 3'd1) ? ST_RESP : ST_BUSY;
                w_cnt_next = i_wb_cyc ? r_cnt - 3'd1 : 3'd0;
            end
            ST_RESP: w_next = ST_GAP;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    assign o_wb_ack = (r_state == ST_RESP) && !r_err;
    assign o_wb_err = (r_state == ST_RESP) && r_err;
    assign o_wb_dat = o_wb_ack ? w_rd : '0;
endmodule

// File: tb/tb_fb_wb_responder.sv
// tb_fb_wb_responder: directed self-checking bench for fb_wb_responder.
module tb_fb_wb_responder;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdat = '0, rdat;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, ack, err;
    logic [3:0]  sel = 4'hF;
    logic [31:0] addr3 = '0, wdat3 = '0, rdat3;
    logic        cyc3 = 1'b0, we3 = 1'b0, ack3, err3;
    logic [3:0]  sel3 = 4'hF;
    int          n_checks = 0, n_errors = 0, n_resp = 0;

    always #5 clk = ~clk;

    fb_wb_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(4096), .RD_LATENCY(2)) u_dut (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_addr(addr), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_sel(sel), .i_wb_dat(wdat), .o_wb_dat(rdat), .o_wb_ack(ack), .o_wb_err(err)
    );

    fb_wb_responder #(.ADDR_BASE(32'h0), .DEPTH_WORDS(16), .RD_LATENCY(3)) u_dut3 (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_addr(addr3), .i_wb_cyc(cyc3), .i_wb_stb(cyc3),
        .i_wb_we(we3), .i_wb_sel(sel3), .i_wb_dat(wdat3), .o_wb_dat(rdat3), .o_wb_ack(ack3), .o_wb_err(err3)
    );

    always @(negedge clk) begin
        n_checks++;
        if ((ack && err) || (ack3 && err3)) begin
            n_errors++;
            $display("FAIL ack_err_exclusive: ack=%b err=%b ack3=%b err3=%b required not both", ack, err, ack3, err3);
        end
        n_checks++;
        if ((!ack && rdat !== 32'h0) || (!ack3 && rdat3 !== 32'h0)) begin
            n_errors++;
            $display("FAIL dat_zero_without_ack: dat=%h dat3=%h required 0", rdat, rdat3);
        end
        if (ack || err) n_resp++;
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string name);
        @(negedge clk);
        addr = a; wdat = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL %s write_ack: ack=%b err=%b required ack=1 err=0", name, ack, err);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0) begin
            n_errors++;
            $display("FAIL %s write_gap: ack=%b required 0", name, ack);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        addr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL %s read_early: ack=%b err=%b required 0 0", name, ack, err);
        end
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b1 || err !== 1'b0 || rdat !== exp) begin
            n_errors++;
            $display("FAIL %s read_data: ack=%b err=%b dat=%h required ack=1 err=0 dat=%h", name, ack, err, rdat, exp);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0) begin
            n_errors++;
            $display("FAIL %s read_gap: ack=%b required 0", name, ack);
        end
    endtask

    task automatic do_err(input logic [31:0] a, input logic w, input string name);
        @(negedge clk);
        addr = a; we = w; wdat = 32'hDEAD_BEEF; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || ack !== 1'b0) begin
            n_errors++;
            $display("FAIL %s err_resp: err=%b ack=%b required err=1 ack=0", name, err, ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || ack !== 1'b0) begin
            n_errors++;
            $display("FAIL %s err_gap: err=%b ack=%b required 0 0", name, err, ack);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || err !== 1'b0 || rdat !== 32'h0 || ack3 !== 1'b0 || err3 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: ack=%b err=%b dat=%h ack3=%b err3=%b required all 0", ack, err, rdat, ack3, err3);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        do_write(BASE + 8, 32'hA1B2_C3D4, 4'hF, "wr_full");
        do_read(BASE + 8, 32'hA1B2_C3D4, "rd_full");
        do_write(BASE + 4 * 4095, 32'h0BAD_F00D, 4'hF, "wr_last_word");
        do_read(BASE + 4 * 4095, 32'h0BAD_F00D, "rd_last_word");
        do_read(BASE + 8 + 3, 32'hA1B2_C3D4, "rd_low_bits_ignored");
    endtask

    task automatic test_byte_lanes;
        do_write(BASE + 8, 32'h0000_00EE, 4'b0001, "wr_lane0");
        do_read(BASE + 8, 32'hA1B2_C3EE, "rd_lane0");
        do_write(BASE + 8, 32'hFFFF_FFFF, 4'b0000, "wr_sel0");
        do_read(BASE + 8, 32'hA1B2_C3EE, "rd_sel0");
        do_write(BASE + 8, 32'h5566_7788, 4'b1000, "wr_lane3");
        do_read(BASE + 8, 32'h55B2_C3EE, "rd_lane3");
    endtask

    task automatic test_range;
        do_err(BASE + 4 * 4096, 1'b0, "rd_past_end");
        do_err(BASE - 4, 1'b0, "rd_below_base");
        do_err(BASE + 4 * 4096 + 8, 1'b1, "wr_alias_past_end");
        do_err(BASE - 32'h0001_0000 + 8, 1'b1, "wr_alias_below_base");
        do_read(BASE + 8, 32'h55B2_C3EE, "rd_untouched");
    endtask

    task automatic test_streaming;
        int idx, last, start;
        for (int i = 0; i < 8; i++) do_write(BASE + 4 * i, i, 4'hF, "preload");
        @(negedge clk);
        start = n_resp;
        addr = BASE; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        idx = 0; last = -1;
        for (int c = 1; c <= 80 && idx < 8; c++) begin
            @(negedge clk);
            if (ack) begin
                n_checks++;
                if (rdat !== 32'(idx) || (idx == 0 && c != 2) || (idx > 0 && c - last != 4)) begin
                    n_errors++;
                    $display("FAIL stream_beat%0d: dat=%h cycle=%0d prev=%0d required dat=%h spacing 4", idx, rdat, c, last, idx);
                end
                last = c;
                idx++;
                if (idx == 8) begin cyc = 1'b0; stb = 1'b0; end
            end else if (last >= 0 && c == last + 2) addr = addr + 4;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (idx != 8 || n_resp - start != 8) begin
            n_errors++;
            $display("FAIL stream_count: acks=%0d responses=%0d required 8 8", idx, n_resp - start);
        end
    endtask

    task automatic test_abort;
        int seen;
        @(negedge clk);
        addr3 = 32'h14; wdat3 = 32'h1234_5678; sel3 = 4'hF; we3 = 1'b1; cyc3 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ack3 !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_setup_write: ack3=%b required 1", ack3);
        end
        cyc3 = 1'b0; we3 = 1'b0;
        repeat (2) @(negedge clk);
        cyc3 = 1'b1; addr3 = 32'h14;
        @(negedge clk);
        cyc3 = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack3 || err3) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL abort_no_ack: responses=%0d required 0", seen);
        end
        cyc3 = 1'b1; addr3 = 32'h14;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ack3 !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_next_early: ack3=%b required 0", ack3);
        end
        @(negedge clk);
        n_checks++;
        if (ack3 !== 1'b1 || rdat3 !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL abort_next_read: ack3=%b dat3=%h required 1 12345678", ack3, rdat3);
        end
        cyc3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int start;
        do_write(BASE + 12, 32'hCAFE_F00D, 4'hF, "wr_before_reset");
        @(negedge clk);
        start = n_resp;
        addr = BASE + 12; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || err !== 1'b0 || rdat !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: ack=%b err=%b dat=%h required 0 0 0", ack, err, rdat);
        end
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (n_resp != start) begin
            n_errors++;
            $display("FAIL reset_mid_late_ack: responses=%0d required 0", n_resp - start);
        end
        do_read(BASE + 12, 32'hCAFE_F00D, "rd_after_reset");
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_byte_lanes;
        test_range;
        test_streaming;
        test_abort;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
